// File: rtl/ucsbece154b_mem_arbiter.sv
// Three-way memory arbiter: data cache, instruction cache and prefetcher share
// one memory port. Fixed d > i > p priority with prefetcher anti-starvation.
module ucsbece154b_mem_arbiter #(
  parameter int BLOCK_WORDS  = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int WW = $clog2(BLOCK_WORDS),
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_wdata_i,
  input  logic          i_req_i,
  input  logic [31:0]   i_addr_i,
  input  logic          p_req_i,
  input  logic [31:0]   p_addr_i,
  output logic          d_gnt_o,
  output logic          i_gnt_o,
  output logic          p_gnt_o,
  output logic          d_done_o,
  output logic          i_done_o,
  output logic          p_done_o,
  output logic [2:0]    rvalid_o,
  output logic [31:0]   rdata_o,
  output logic [WW-1:0] rword_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ, DONE} state_t;

  localparam logic [1:0]  OWN_D = 2'd0;
  localparam logic [1:0]  OWN_I = 2'd1;
  localparam logic [1:0]  OWN_P = 2'd2;
  localparam logic [31:0] READ_MASK  = ~(32'(BLOCK_WORDS * 4) - 32'd1);
  localparam logic [31:0] WRITE_MASK = ~32'd3;

  state_t        state, state_n;
  logic [1:0]    owner;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [WW-1:0] beat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          first_q;

  logic          any_req;
  logic          p_promote;
  logic [1:0]    win;
  logic          win_we;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic [2:0]    owner_oh;
  logic          beat;
  logic [2:0]    gnt_v;
  logic [2:0]    done_v;

  // Winner selection; the prefetcher jumps the queue once it has lost enough times.
  always_comb begin
    any_req   = d_req_i | i_req_i | p_req_i;
    p_promote = p_req_i && (starve_cnt == SW'(STARVE_LIMIT));
    win       = OWN_P;
    if (p_promote)    win = OWN_P;
    else if (d_req_i) win = OWN_D;
    else if (i_req_i) win = OWN_I;
    win_we    = (win == OWN_D) ? d_we_i : 1'b0;
    win_wdata = (win == OWN_D) ? d_wdata_i : 32'd0;
    case (win)
      OWN_D:   win_addr = d_addr_i;
      OWN_I:   win_addr = i_addr_i;
      default: win_addr = p_addr_i;
    endcase
    win_addr = win_addr & (win_we ? WRITE_MASK : READ_MASK);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (any_req) state_n = ISSUE;
      ISSUE: if (mem_ack_i) state_n = we_q ? DONE : READ;
      READ:  if (mem_rvalid_i && beat_cnt == WW'(BLOCK_WORDS - 1)) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, not only after the next edge.
  always_comb begin
    owner_oh    = 3'b001 << owner;
    beat        = reset && (state == READ) && mem_rvalid_i;
    mem_req_o   = reset && (state == ISSUE);
    mem_we_o    = mem_req_o && we_q;
    mem_addr_o  = mem_req_o ? addr_q : 32'd0;
    mem_wdata_o = mem_req_o ? wdata_q : 32'd0;
    gnt_v       = (mem_req_o && first_q) ? owner_oh : 3'b000;
    done_v      = (reset && state == DONE) ? owner_oh : 3'b000;
    rvalid_o    = beat ? owner_oh : 3'b000;
    rdata_o     = beat ? mem_rdata_i : 32'd0;
    rword_o     = beat ? beat_cnt : '0;
    busy_o      = reset && (state != IDLE);
    d_gnt_o     = gnt_v[0];
    i_gnt_o     = gnt_v[1];
    p_gnt_o     = gnt_v[2];
    d_done_o    = done_v[0];
    i_done_o    = done_v[1];
    p_done_o    = done_v[2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_D;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      first_q    <= 1'b0;
    end else begin
      state   <= state_n;
      first_q <= (state == IDLE) && any_req;
      if (state == IDLE && any_req) begin
        owner    <= win;
        we_q     <= win_we;
        addr_q   <= win_addr;
        wdata_q  <= win_wdata;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + WW'(1);
      end
      if (state == IDLE) begin
        if (any_req && win == OWN_P)
          starve_cnt <= '0;
        else if (!p_req_i)
          starve_cnt <= '0;
        else if (any_req && starve_cnt != SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for the three-way memory arbiter; the bench plays the memory
// and checks grants, bursts, writes, starvation promotion and reset abandonment.
module tb_ucsbece154b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, d_we, i_req, p_req;
  logic [31:0] d_addr, d_wdata, i_addr, p_addr;
  logic        d_gnt, i_gnt, p_gnt, d_done, i_done, p_done;
  logic [2:0]  rvalid;
  logic [31:0] rdata;
  logic [1:0]  rword;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wire [2:0] gnt_v  = {p_gnt, i_gnt, d_gnt};
  wire [2:0] done_v = {p_done, i_done, d_done};

  ucsbece154b_mem_arbiter #(.BLOCK_WORDS(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .i_req_i(i_req), .i_addr_i(i_addr), .p_req_i(p_req), .p_addr_i(p_addr),
    .d_gnt_o(d_gnt), .i_gnt_o(i_gnt), .p_gnt_o(p_gnt),
    .d_done_o(d_done), .i_done_o(i_done), .p_done_o(p_done),
    .rvalid_o(rvalid), .rdata_o(rdata), .rword_o(rword),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drop_req(input int who);
    case (who)
      0: d_req = 1'b0;
      1: i_req = 1'b0;
      default: p_req = 1'b0;
    endcase
  endtask

  // Bounded wait for the given requester's grant pulse.
  task automatic wait_gnt(input int who, input int limit, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      step();
      #1;
      if (gnt_v[who]) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_gnt_timeout"}, 32'(gnt_v), 32'(1) << who);
    else       checkOutput({tag, "_gnt"}, 32'(gnt_v), 32'(1) << who);
  endtask

  // Returns at the DONE-cycle sample point.
  task automatic run_read(input int who, input int limit, input logic [31:0] exp_addr,
                          input logic [31:0] seed, input string tag);
    wait_gnt(who, limit, tag);
    drop_req(who);
    checkOutput({tag, "_addr"}, mem_addr, exp_addr);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    step(); #1;
    checkOutput({tag, "_gnt_pulse"}, 32'(gnt_v), 32'd0);
    checkOutput({tag, "_req_held"}, 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = seed + 32'(b);
      #1;
      checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'(1) << who);
      checkOutput({tag, "_rword"}, 32'(rword), 32'(b));
      checkOutput({tag, "_rdata"}, rdata, seed + 32'(b));
      step();
    end
    mem_rvalid = 1'b0;
    #1;
    checkOutput({tag, "_done"}, 32'(done_v), 32'(1) << who);
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  task automatic run_write(input int limit, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input string tag);
    wait_gnt(0, limit, tag);
    drop_req(0);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
    checkOutput({tag, "_addr"}, mem_addr, exp_addr);
    checkOutput({tag, "_wdata"}, mem_wdata, exp_wdata);
    step(); #1;
    checkOutput({tag, "_addr_held"}, mem_addr, exp_addr);
    mem_ack = 1'b1;
    #1;
    checkOutput({tag, "_req_at_ack"}, 32'(mem_req), 32'd1);
    step();
    mem_ack = 1'b0;
    #1;
    checkOutput({tag, "_done"}, 32'(done_v), 32'd1);
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    checkOutput({tag, "_req_off"}, 32'(mem_req), 32'd0);
  endtask

  task automatic idle_gap(input string tag);
    step(); #1;
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idle_gnt"}, 32'(gnt_v), 32'd0);
    checkOutput({tag, "_idle_done"}, 32'(done_v), 32'd0);
  endtask

  task automatic applyStimulus(input int k);
    if (k % 2 == 0) begin
      d_req = 1'b1; d_we = 1'b1;
      d_addr = 32'h0000_0100 + 32'(k * 4); d_wdata = 32'h1111_0000 + 32'(k);
    end else begin
      i_req = 1'b1; i_addr = 32'h0000_0044;
    end
  endtask

  initial begin
    reset = 1'b0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; p_req = 0; p_addr = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;

    step(); step();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_memreq", 32'(mem_req), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    mem_rvalid = 1'b0;
    reset = 1'b1;
    idle_gap("post_rst");

    i_req = 1'b1; i_addr = 32'h0000_1234;
    run_read(1, 2, 32'h0000_1230, 32'hA0A0_0000, "iread");
    idle_gap("iread");

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0107; d_wdata = 32'hDEAD_BEEF;
    run_write(2, 32'h0000_0104, 32'hDEAD_BEEF, "dwrite");
    idle_gap("dwrite");

    d_we = 1'b0; d_addr = 32'h0000_2018; i_addr = 32'h3000_003C; p_addr = 32'h4000_0005;
    d_req = 1'b1; i_req = 1'b1; p_req = 1'b1;
    run_read(0, 2, 32'h0000_2010, 32'hD000_0000, "prio_d");
    idle_gap("prio_d");
    run_read(1, 1, 32'h3000_0030, 32'hC000_0000, "prio_i");
    idle_gap("prio_i");
    run_read(2, 1, 32'h4000_0000, 32'hB000_0000, "prio_p");
    idle_gap("prio_p");

    // Keep a d or i request pending at every IDLE so the prefetcher keeps losing.
    p_req = 1'b1; p_addr = 32'h5000_0010;
    applyStimulus(0);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) run_write(1, 32'h0000_0100 + 32'(k * 4), 32'h1111_0000 + 32'(k), "starve_d");
      else            run_read(1, 1, 32'h0000_0040, 32'h2000_0000 + 32'(k * 16), "starve_i");
      if (k < 7) applyStimulus(k + 1);
      else begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
      end
      idle_gap("starve");
    end
    run_read(2, 1, 32'h5000_0010, 32'h3000_0000, "starve_p");
    checkOutput("starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
    idle_gap("starve_p");
    run_read(0, 1, 32'h0000_0300, 32'h4000_0000, "after_p_d");
    idle_gap("after_p_d");

    i_req = 1'b1; i_addr = 32'h0000_0080;
    wait_gnt(1, 2, "rstmid");
    drop_req(1);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h7700_0000 + 32'(b);
      #1;
      checkOutput("rstmid_rvalid", 32'(rvalid), 32'b010);
      step();
    end
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7700_0002;
    step();
    reset = 1'b1; mem_rdata = 32'h7700_0003;
    #1;
    checkOutput("rstmid_rvalid_after", 32'(rvalid), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_memreq", 32'(mem_req), 32'd0);
    checkOutput("rstmid_done", 32'(done_v), 32'd0);
    step();
    mem_rvalid = 1'b0;
    #1;
    checkOutput("rstmid_no_done", 32'(done_v), 32'd0);
    checkOutput("rstmid_idle", 32'(busy), 32'd0);

    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    checkOutput("stray_rvalid", 32'(rvalid), 32'd0);
    checkOutput("stray_busy", 32'(busy), 32'd0);
    step();
    #1;
    checkOutput("stray_stay_idle", 32'(busy), 32'd0);
    checkOutput("stray_rvalid2", 32'(rvalid), 32'd0);
    mem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_mem_arbiter.md
UCSBECE154B_MEM_ARBITER -- requirements
Module: ucsbece154b_mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 4, words per read burst (power of 2, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8, lost arbitrations before the prefetcher is promoted (>=1).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 d_req_i / d_we_i  in  1/1  data-cache request; 1 = single-word write, 0 = block read.
REQ-006 d_addr_i / d_wdata_i  in  32/32  data-cache byte address and write data.
REQ-007 i_req_i / i_addr_i  in  1/32  instruction-cache block-read request and address.
REQ-008 p_req_i / p_addr_i  in  1/32  prefetcher block-read request and address.
REQ-009 d_gnt_o, i_gnt_o, p_gnt_o  out  1 each  one-cycle grant pulse to the selected requester.
REQ-010 d_done_o, i_done_o, p_done_o  out  1 each  one-cycle completion pulse to the owner.
REQ-011 rvalid_o  out  3  one-hot read-beat strobe {p,i,d}, bit 0 = d.
REQ-012 rdata_o / rword_o  out  32/clog2(BLOCK_WORDS)  read beat data and beat index.
REQ-013 mem_req_o / mem_we_o  out  1/1  memory request and write enable.
REQ-014 mem_addr_o / mem_wdata_o  out  32/32  memory address and write data.
REQ-015 mem_ack_i  in  1  memory accepted the request; for a write, also marks the write complete.
REQ-016 mem_rvalid_i / mem_rdata_i  in  1/32  memory read beat strobe and data.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, READ, DONE.
REQ-019 Arbitration happens only in IDLE; base priority is d > i > p.
REQ-020 When starve_cnt == STARVE_LIMIT and p_req_i=1, p wins over d and i.
REQ-021 On IDLE with any request: latch owner, we, addr, and wdata; go to ISSUE; pulse the owner's gnt_o in the first ISSUE cycle.
REQ-022 A requester may drop req_i after its gnt_o; the latched values are used for the rest of the transaction.
REQ-023 Read address is aligned down to BLOCK_WORDS*4 bytes; write address has bits [1:0] forced to 0.
REQ-024 ISSUE: mem_req_o=1 with the latched addr, we, and wdata, held until mem_ack_i=1.
REQ-025 On ack, a write goes to DONE and a read goes to READ.
REQ-026 READ: each mem_rvalid_i=1 drives rvalid_o[owner]=1, rdata_o=mem_rdata_i, and rword_o=beat count in the same cycle (combinational).
REQ-027 The beat count increments on each beat and returns to 0 at the wrap point; the beat with index BLOCK_WORDS-1 moves the FSM to DONE.
REQ-028 mem_rvalid_i is ignored outside READ; rvalid_o=0 there.
REQ-029 DONE lasts one cycle: owner's done_o=1, then IDLE. Minimum one idle cycle between transactions.
REQ-030 starve_cnt: on a d or i grant while p_req_i=1, +1, saturating at STARVE_LIMIT.
REQ-031 starve_cnt clears to 0 on a p grant, and in IDLE when p_req_i=0.
REQ-032 Requests that arrive during a non-IDLE state wait and are arbitrated on the return to IDLE; no preemption.
REQ-033 A new request in the same cycle as DONE is not arbitrated until the next IDLE cycle.

Reset
REQ-034 reset=0 at posedge: FSM=IDLE; owner, beat count, and starve_cnt=0; latched addr and wdata=0.
REQ-035 During reset all outputs are 0, including mem_req_o, gnt_o, done_o, rvalid_o, and busy_o.
REQ-036 Reset mid-transaction abandons it: mem_req_o drops the next cycle and no done_o is issued.
REQ-037 Beats that arrive after reset are discarded.

Verification
REQ-038 Single i read: i_req_i=1, i_addr_i=0x0000_1234, ack after 2 cycles, 4 beats A..D -> i_gnt_o pulse; mem_addr_o=0x0000_1230; rvalid_o=3'b010 with rword_o 0..3 and data A..D; one i_done_o; busy_o low next cycle.
REQ-039 d_req_i, i_req_i, p_req_i all high in IDLE -> d granted first, then i, then p; each done_o precedes the next gnt_o by >=1 idle cycle.
REQ-040 d write: d_we_i=1, d_addr_i=0x0000_0107, d_wdata_i=0xDEADBEEF -> mem_we_o=1, mem_addr_o=0x0000_0104 until ack; d_done_o the cycle after ack; rvalid_o stays 0.
REQ-041 Starvation: p_req_i held high while d and i alternate for 8 grants -> 9th arbitration grants p even with d_req_i=1; starve_cnt returns to 0.
REQ-042 Reset mid-burst: reset=0 after 2 of 4 beats -> all outputs 0 next cycle; no done_o; the remaining mem_rvalid_i beats give rvalid_o=0.
REQ-043 Stray beat: mem_rvalid_i=1 in IDLE -> rvalid_o=0 and the FSM stays in IDLE.
